key_debouncer: RTL
==================

// Module: key_debouncer
// PURPOSE
//   Conditions one raw active-low push-button into clean level and pulse events.
//   Sits upstream of the LED pattern/looper logic on the board and drives its key inputs.
//   Contains a 2-flop synchroniser, a stability-count filter and auto-repeat while held.
//   Outputs are registered; the block runs on the same board clock as its consumer.
// PARAMETERS
//   STABLE_CYCLES  550000  consecutive stable sync'd samples needed to accept a change (>=1, <2^24)
//   HOLD_CYCLES    5529600 cycles in PRESSED before first repeat_pulse (>=1, <2^24)
//   REPEAT_CYCLES  1105920 cycles between later repeat_pulses; 0 disables auto-repeat (<2^24)
// PORTS
//   clk            in   1   board clock, all logic on posedge
//   rst_key        in   1   synchronous reset, active-low
//   key_raw        in   1   asynchronous button, 0 = pressed, 1 = released
//   key_down       out  1   debounced level, 1 while accepted pressed
//   press_pulse    out  1   one-cycle pulse on accepted press
//   release_pulse  out  1   one-cycle pulse on accepted release
//   repeat_pulse   out  1   one-cycle pulse per auto-repeat tick while held
//   press_cnt      out  8   count of accepted presses, wraps 255 -> 0
// BEHAVIOUR
//   Reset (rst_key==0 at posedge): s1=s2=1, state=RELEASED, stab_cnt=hold_cnt=0,
//     all outputs 0, press_cnt=0. Overrides everything; in-flight pulses dropped.
//   Sync: s1<=key_raw, s2<=s1; FSM sees s2 only. Edge 0 = first edge sampling key_raw=0.
//   States (2-bit): RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
//   RELEASED: s2==0 -> PRESS_WAIT, stab_cnt<=0.
//   PRESS_WAIT: s2==1 -> RELEASED (bounce, no event); s2==0 & stab_cnt==STABLE_CYCLES-1
//     -> PRESSED, press_pulse<=1, key_down<=1, press_cnt<=press_cnt+1, hold_cnt<=0,
//     first_rep<=1; else stab_cnt<=stab_cnt+1.
//   PRESSED: s2==1 -> RELEASE_WAIT, stab_cnt<=0 (hold_cnt frozen); else hold_cnt++;
//     first_rep & hold_cnt==HOLD_CYCLES-1 -> repeat_pulse<=1, hold_cnt<=0, first_rep<=0;
//     !first_rep & REPEAT_CYCLES!=0 & hold_cnt==REPEAT_CYCLES-1 -> repeat_pulse<=1, hold_cnt<=0.
//   RELEASE_WAIT: s2==0 -> PRESSED (glitch, hold_cnt resumes, no events);
//     s2==1 & stab_cnt==STABLE_CYCLES-1 -> RELEASED, release_pulse<=1, key_down<=0;
//     else stab_cnt++.
//   Latency: clean press -> press_pulse & key_down high after edge STABLE_CYCLES+2;
//     clean release symmetric -> release_pulse high after edge STABLE_CYCLES+2.
//   Pulses are exactly one cycle; never two of press/release/repeat in the same cycle.
//   key_down stays 1 through RELEASE_WAIT; changes only with press/release pulses.
//   Counters are 24-bit, compare by equality, never exceed parameter-1; no wrap in use.
//   hold_cnt is held at 0 when REPEAT_CYCLES==0 after the first repeat.
// TESTING (STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3 unless noted)
//   Reset: rst_key=0 for 3 cycles, key_raw=0 -> all outputs 0, press_cnt=0, no pulse after release of reset until edge 6.
//   Clean press at edge 0 held -> press_pulse=1 only after edge 6, key_down=1, press_cnt=1.
//   Bounce: key_raw low 2 cycles, high, low 2, high -> no pulses, key_down stays 0.
//   Hold 40 cycles after press -> repeat_pulse at press+10, then every 3 cycles (+13, +16, ...).
//   REPEAT_CYCLES=0, hold 40 -> exactly one repeat_pulse at press+10.
//   Release glitch 2 cycles while held -> no release_pulse, key_down stays 1; 256 presses -> press_cnt=0.
//   rst_key=0 mid PRESS_WAIT -> no press_pulse, state RELEASED, press_cnt unchanged at 0.

Source files
------------

// File: rtl/key_debouncer.sv
// Debounces one raw active-low push-button: 2-flop synchroniser, stability-count
// filter, and auto-repeat while held. All outputs are registered.
module key_debouncer #(
  parameter int STABLE_CYCLES = 550000,
  parameter int HOLD_CYCLES   = 5529600,
  parameter int REPEAT_CYCLES = 1105920
) (
  input  logic       clk,
  input  logic       rst_key,
  input  logic       key_raw,
  output logic       key_down,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [23:0] STAB_LAST = 24'(STABLE_CYCLES - 1);
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
  // Guarded so a disabled repeat never produces a negative terminal count.
  localparam logic [23:0] REP_LAST  = (REPEAT_CYCLES == 0) ? 24'd0 : 24'(REPEAT_CYCLES - 1);
  localparam bit          REPEAT_EN = (REPEAT_CYCLES != 0);

  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  state_e      state_q, state_d;
  logic [23:0] stab_cnt_q, stab_cnt_d;
  logic [23:0] hold_cnt_q, hold_cnt_d;
  logic        first_rep_q, first_rep_d;
  logic        key_down_q, key_down_d;
  logic        press_pulse_q, press_pulse_d;
  logic        release_pulse_q, release_pulse_d;
  logic        repeat_pulse_q, repeat_pulse_d;
  logic [7:0]  press_cnt_q, press_cnt_d;

  always_comb begin
    s1_d            = key_raw;
    s2_d            = s1_q;
    state_d         = state_q;
    stab_cnt_d      = stab_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    first_rep_d     = first_rep_q;
    key_down_d      = key_down_q;
    press_cnt_d     = press_cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    repeat_pulse_d  = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        if (!s2_q) begin
          state_d    = ST_PRESS_WAIT;
          stab_cnt_d = 24'd0;
        end
      end

      ST_PRESS_WAIT: begin
        if (s2_q) begin
          state_d = ST_RELEASED;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d       = ST_PRESSED;
          press_pulse_d = 1'b1;
          key_down_d    = 1'b1;
          press_cnt_d   = press_cnt_q + 8'd1;
          hold_cnt_d    = 24'd0;
          first_rep_d   = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + 24'd1;
        end
      end

      ST_PRESSED: begin
        if (s2_q) begin
          // hold_cnt is left untouched so a short glitch resumes the repeat timing.
          state_d    = ST_RELEASE_WAIT;
          stab_cnt_d = 24'd0;
        end else if (first_rep_q) begin
          if (hold_cnt_q == HOLD_LAST) begin
            repeat_pulse_d = 1'b1;
            hold_cnt_d     = 24'd0;
            first_rep_d    = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt_q + 24'd1;
          end
        end else if (!REPEAT_EN) begin
          hold_cnt_d = 24'd0;
        end else if (hold_cnt_q == REP_LAST) begin
          repeat_pulse_d = 1'b1;
          hold_cnt_d     = 24'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 24'd1;
        end
      end

      ST_RELEASE_WAIT: begin
        if (!s2_q) begin
          state_d = ST_PRESSED;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d         = ST_RELEASED;
          release_pulse_d = 1'b1;
          key_down_d      = 1'b0;
        end else begin
          stab_cnt_d = stab_cnt_q + 24'd1;
        end
      end

      default: begin
        state_d = ST_RELEASED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_key) begin
      s1_q            <= 1'b1;
      s2_q            <= 1'b1;
      state_q         <= ST_RELEASED;
      stab_cnt_q      <= 24'd0;
      hold_cnt_q      <= 24'd0;
      first_rep_q     <= 1'b0;
      key_down_q      <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      repeat_pulse_q  <= 1'b0;
      press_cnt_q     <= 8'd0;
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      state_q         <= state_d;
      stab_cnt_q      <= stab_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      first_rep_q     <= first_rep_d;
      key_down_q      <= key_down_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      repeat_pulse_q  <= repeat_pulse_d;
      press_cnt_q     <= press_cnt_d;
    end
  end

  assign key_down      = key_down_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign repeat_pulse  = repeat_pulse_q;
  assign press_cnt     = press_cnt_q;
  assign dbg_state     = state_q;

endmodule
